// File: rtl/pipeline_link_receiver_pkg.sv
// Shared definitions for the pipeline link receiver: default geometry,
// the link word type and helpers used for sizing and legality checks.
package pipeline_link_receiver_pkg;

    localparam int DEFAULT_DATA_WIDTH     = 32;
    localparam int DEFAULT_PIPELINE_LEVEL = 2;
    localparam int DEFAULT_DEPTH          = 16;
    localparam int DEFAULT_ADDR_WIDTH     = 4;

    // One payload word as carried by the link.
    typedef logic [DEFAULT_DATA_WIDTH-1:0] link_word_t;

    // Slots that must stay free when in_ready drops: one full round trip
    // (forward + return pipeline) plus the in_ready register stage.
    function automatic int calc_reserve(input int pipeline_level);
        return 2 * pipeline_level + 1;
    endfunction

    // True when v is a non-zero power of two.
    function automatic bit is_pow2(input int v);
        return (v > 0) && ((v & (v - 1)) == 0);
    endfunction

endpackage

// File: rtl/pipeline_link_receiver_if.sv
// Valid/ready/data bundle used on both sides of the receiver.
// master drives valid/data and samples ready; slave does the opposite.
interface pipeline_link_receiver_if
    import pipeline_link_receiver_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
);

    logic                  valid;
    logic [DATA_WIDTH-1:0] data;
    logic                  ready;

    modport master (
        output valid,
        output data,
        input  ready
    );

    modport slave (
        input  valid,
        input  data,
        output ready
    );

endinterface

// File: rtl/pipeline_helper.sv
// Plain register pipeline of LEVEL stages, used to model each direction
// of the link between sender and receiver.
module pipeline_helper #(
    parameter int WIDTH = 1,
    parameter int LEVEL = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] data_i,
    output logic [WIDTH-1:0] data_o
);

    logic [WIDTH-1:0] stage_q [LEVEL];

    // Shift the payload one stage per clock; reset clears every stage.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < LEVEL; i++) begin
                stage_q[i] <= '0;
            end
        end else begin
            stage_q[0] <= data_i;
            for (int i = 1; i < LEVEL; i++) begin
                stage_q[i] <= stage_q[i-1];
            end
        end
    end

    assign data_o = stage_q[LEVEL-1];

endmodule

// File: rtl/pipeline_link_receiver_link_fifo_mem.sv
// Register-array storage for the receiver FIFO: one synchronous write
// port, one asynchronous (combinational) read port.
module link_fifo_mem
    import pipeline_link_receiver_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int DEPTH      = DEFAULT_DEPTH,
    parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  wr_en_i,
    input  logic [ADDR_WIDTH-1:0] wr_addr_i,
    input  logic [DATA_WIDTH-1:0] wr_data_i,
    input  logic [ADDR_WIDTH-1:0] rd_addr_i,
    output logic [DATA_WIDTH-1:0] rd_data_o
);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    // Store the incoming word at the write address.
    // NOTE: the array has no reset; pointers and count alone decide which
    // entries are meaningful, so clearing storage would only add logic.
    always_ff @(posedge clk) begin
        if (wr_en_i) begin
            mem_q[wr_addr_i] <= wr_data_i;
        end
    end

    // Fall-through read: the head entry is always visible.
    assign rd_data_o = mem_q[rd_addr_i];

endmodule

// File: rtl/pipeline_link_receiver.sv
// Far-end receiver of a pipelined valid/ready link. Words keep arriving for
// a full round trip after in_ready drops, so the FIFO keeps RESERVE slots
// spare above the in_ready threshold to absorb them. The local consumer
// sees a first-word-fall-through valid/ready interface.
module pipeline_link_receiver
    import pipeline_link_receiver_pkg::*;
#(
    parameter int DATA_WIDTH     = DEFAULT_DATA_WIDTH,
    parameter int PIPELINE_LEVEL = DEFAULT_PIPELINE_LEVEL,
    parameter int DEPTH          = DEFAULT_DEPTH,
    parameter int ADDR_WIDTH     = DEFAULT_ADDR_WIDTH
) (
    input  logic                    clk,
    input  logic                    rst_n,
    pipeline_link_receiver_if.slave  in_if,
    pipeline_link_receiver_if.master out_if,
    output logic [ADDR_WIDTH:0]     level,
    output logic                    overflow
);

    localparam int                  RESERVE   = calc_reserve(PIPELINE_LEVEL);
    localparam logic [ADDR_WIDTH:0] DEPTH_C   = (ADDR_WIDTH+1)'(DEPTH);
    localparam logic [ADDR_WIDTH:0] RESERVE_C = (ADDR_WIDTH+1)'(RESERVE);

    // Parameter legality, rejected at elaboration.
    if (PIPELINE_LEVEL < 1) begin : g_bad_pipeline_level
        $error("pipeline_link_receiver: PIPELINE_LEVEL must be at least 1");
    end
    if (!is_pow2(DEPTH)) begin : g_bad_depth_pow2
        $error("pipeline_link_receiver: DEPTH must be a power of 2");
    end
    if (DEPTH <= RESERVE) begin : g_bad_depth_reserve
        $error("pipeline_link_receiver: DEPTH must exceed 2*PIPELINE_LEVEL+1");
    end
    if (ADDR_WIDTH != $clog2(DEPTH)) begin : g_bad_addr_width
        $error("pipeline_link_receiver: ADDR_WIDTH must equal log2(DEPTH)");
    end

    logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_WIDTH:0]   count_q,  count_d;
    logic                  overflow_q, overflow_d;
    logic                  in_ready_q, in_ready_d;

    logic                  out_valid;
    logic                  push;
    logic                  pop;
    logic                  drop;
    logic [DATA_WIDTH-1:0] rd_data;

    // Handshake decode. A pop frees the slot a simultaneous push uses, so a
    // full FIFO still accepts a word in the same cycle its head leaves.
    // NOTE: every signal driven here gets a value on every path, so the
    // block stays purely combinational with no inferred latch.
    always_comb begin
        out_valid = (count_q != '0);
        pop       = out_valid && out_if.ready;
        push      = in_if.valid && ((count_q < DEPTH_C) || pop);
        drop      = in_if.valid && !push;
    end

    // Next-state for pointers, occupancy, overflow flag and returned ready.
    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        overflow_d = overflow_q | drop;

        // Pointers wrap through natural ADDR_WIDTH overflow.
        if (push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end

        count_d = count_q + (ADDR_WIDTH+1)'(push) - (ADDR_WIDTH+1)'(pop);

        // in_ready comes from next occupancy, so it is registered alongside
        // the count and never depends combinationally on in_valid/out_ready
        // at the port.
        in_ready_d = ((DEPTH_C - count_d) > RESERVE_C);
    end

    // State registers; the link starts empty and ready.
    // NOTE: non-blocking assignments let every register sample pre-edge
    // values, independent of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            in_ready_q <= 1'b1;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
            in_ready_q <= in_ready_d;
        end
    end

    link_fifo_mem #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_mem (
        .clk       (clk),
        .wr_en_i   (push),
        .wr_addr_i (wr_ptr_q),
        .wr_data_i (in_if.data),
        .rd_addr_i (rd_ptr_q),
        .rd_data_o (rd_data)
    );

    assign in_if.ready  = in_ready_q;
    assign out_if.valid = out_valid;
    assign out_if.data  = rd_data;
    assign level        = count_q;
    assign overflow     = overflow_q;

endmodule

// File: tb/tb_pipeline_link_receiver.sv
// Bench for pipeline_link_receiver: sender model behind a forward pipeline,
// ready returned through a second pipeline, scoreboard checked by a
// monitor that pops expected words whenever the consumer takes one.
module tb_pipeline_link_receiver;
    import pipeline_link_receiver_pkg::*;

    localparam int DW      = 32;
    localparam int PL      = 2;
    localparam int DEPTH   = 16;
    localparam int AW      = 4;
    localparam int RESERVE = 5;   // 2*PL + 1

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    pipeline_link_receiver_if #(.DATA_WIDTH(DW)) link_if ();
    pipeline_link_receiver_if #(.DATA_WIDTH(DW)) out_if ();

    logic          snd_valid  = 1'b0;
    logic [DW-1:0] snd_data   = '0;
    logic          snd_ready;
    logic          cons_ready = 1'b0;
    logic [DW:0]   fwd_out;
    logic          ret_out;
    logic [AW:0]   level;
    logic          overflow;

    pipeline_helper #(.WIDTH(DW+1), .LEVEL(PL)) u_fwd (
        .clk    (clk),
        .rst_n  (rst_n),
        .data_i ({snd_valid, snd_data}),
        .data_o (fwd_out)
    );
    assign link_if.valid = fwd_out[DW];
    assign link_if.data  = fwd_out[DW-1:0];

    pipeline_helper #(.WIDTH(1), .LEVEL(PL)) u_ret (
        .clk    (clk),
        .rst_n  (rst_n),
        .data_i (link_if.ready),
        .data_o (ret_out)
    );
    assign snd_ready    = ret_out;
    assign out_if.ready = cons_ready;

    pipeline_link_receiver #(
        .DATA_WIDTH     (DW),
        .PIPELINE_LEVEL (PL),
        .DEPTH          (DEPTH),
        .ADDR_WIDTH     (AW)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_if    (link_if),
        .out_if   (out_if),
        .level    (level),
        .overflow (overflow)
    );

    int         checks = 0;
    int         errors = 0;
    link_word_t exp_q [$];
    link_word_t exp_word;

    bit burst_phase   = 1'b0;
    bit wrap_phase    = 1'b0;
    bit ready_dropped = 1'b0;
    bit prev_in_ready = 1'b1;
    int max_level     = 0;
    int arr_cnt       = 0;
    int pop_cnt       = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: compares consumed words against the scoreboard and tracks
    // level / in_ready behaviour, sampled on the falling edge.
    always @(negedge clk) begin
        if (rst_n) begin
            if (wrap_phase) begin
                check("wrap_level_eq_push_minus_pop", level, arr_cnt - pop_cnt);
                if (link_if.valid) arr_cnt++;
            end
            if (out_if.valid && out_if.ready) begin
                pop_cnt++;
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_output: got=%0h expected=none", out_if.data);
                end else begin
                    exp_word = exp_q.pop_front();
                    check("out_data", out_if.data, exp_word);
                end
            end
            if (int'(level) > max_level) max_level = int'(level);
            if (!link_if.ready) ready_dropped = 1'b1;
            if (burst_phase && prev_in_ready && !link_if.ready)
                check("in_ready_fall_level", level, DEPTH - RESERVE);
            prev_in_ready = link_if.ready;
        end
    end

    // Compliant sender: only issues a word while the returned ready is high.
    task automatic send_stream(input int base, input int n);
        int sent = 0;
        int cyc  = 0;
        while (sent < n && cyc < 3000) begin
            @(posedge clk); #1;
            cyc++;
            if (snd_ready) begin
                snd_valid = 1'b1;
                snd_data  = DW'(base + sent);
                exp_q.push_back(snd_data);
                sent++;
            end else begin
                snd_valid = 1'b0;
            end
        end
        @(posedge clk); #1;
        snd_valid = 1'b0;
        check("send_complete", sent, n);
    endtask

    // Sender that ignores ready; one word, then idle for a cycle.
    task automatic raw_send(input logic [DW-1:0] data, input bit expect_accept);
        @(posedge clk); #1;
        snd_valid = 1'b1;
        snd_data  = data;
        if (expect_accept) exp_q.push_back(data);
        @(posedge clk); #1;
        snd_valid = 1'b0;
    endtask

    task automatic wait_level(input int target, input string name);
        int cyc = 0;
        while (int'(level) != target && cyc < 500) begin
            @(negedge clk);
            cyc++;
        end
        check(name, level, target);
    endtask

    task automatic wait_empty(input string name);
        int cyc = 0;
        while (exp_q.size() != 0 && cyc < 2000) begin
            @(negedge clk);
            cyc++;
        end
        check(name, exp_q.size(), 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Reset then idle
        repeat (3) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        repeat (2) @(negedge clk);
        check("reset_in_ready",  link_if.ready, 1);
        check("reset_out_valid", out_if.valid, 0);
        check("reset_level",     level, 0);
        check("reset_overflow",  overflow, 0);

        // Asynchronous reset with five words stored
        cons_ready = 1'b0;
        send_stream(0, 5);
        wait_level(5, "pre_reset_level");
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_in_ready",  link_if.ready, 1);
        check("async_rst_out_valid", out_if.valid, 0);
        check("async_rst_level",     level, 0);
        check("async_rst_overflow",  overflow, 0);
        exp_q.delete();
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;

        // Streaming with an always-ready consumer
        @(posedge clk); #1;
        cons_ready    = 1'b1;
        max_level     = 0;
        ready_dropped = 1'b0;
        send_stream(0, 100);
        wait_empty("stream_drained");
        check("stream_level_le_2",   max_level <= 2, 1);
        check("stream_in_ready_held", ready_dropped, 0);

        // Stalled consumer, compliant burst: settles at 11 + 2*PL = 15
        @(posedge clk); #1;
        cons_ready    = 1'b0;
        max_level     = 0;
        ready_dropped = 1'b0;
        burst_phase   = 1'b1;
        fork
            send_stream(200, 20);
            begin
                repeat (40) @(negedge clk);
                check("burst_settled_level", level, 15);
                check("burst_level_le_depth", max_level <= DEPTH, 1);
                check("burst_overflow", overflow, 0);
                check("burst_in_ready_dropped", ready_dropped, 1);
                @(posedge clk); #1;
                cons_ready = 1'b1;
            end
        join
        burst_phase = 1'b0;
        wait_empty("burst_drained");
        wait_level(0, "burst_level_zero");

        // Full FIFO with simultaneous push and pop
        @(posedge clk); #1;
        cons_ready = 1'b0;
        for (int i = 0; i < 16; i++) raw_send(DW'(300 + i), 1'b1);
        wait_level(16, "fill_level");
        raw_send(32'h0000_0AAA, 1'b1);
        repeat (PL - 1) begin
            @(posedge clk); #1;
        end
        cons_ready = 1'b1;
        @(posedge clk); #1;
        cons_ready = 1'b0;
        @(negedge clk);
        check("full_pushpop_level",    level, 16);
        check("full_pushpop_overflow", overflow, 0);

        // Non-compliant sender at full: word is dropped, flag is sticky
        raw_send(32'h0000_DEAD, 1'b0);
        repeat (PL) @(posedge clk);
        @(negedge clk);
        check("drop_overflow", overflow, 1);
        check("drop_level",    level, 16);
        repeat (5) @(negedge clk);
        check("drop_overflow_sticky", overflow, 1);
        @(posedge clk); #1;
        cons_ready = 1'b1;
        wait_empty("drop_drained");
        wait_level(0, "drop_level_zero");
        check("overflow_after_drain", overflow, 1);
        @(posedge clk); #1;
        cons_ready = 1'b0;

        // Reset clears the sticky flag
        @(negedge clk) rst_n = 1'b0;
        #1 check("overflow_cleared_by_reset", overflow, 0);
        @(negedge clk) rst_n = 1'b1;

        // Wrap-around with a random consumer: 56 words, three pointer wraps
        arr_cnt    = 0;
        pop_cnt    = 0;
        wrap_phase = 1'b1;
        fork
            send_stream(1000, 56);
            begin
                int cyc = 0;
                while (pop_cnt < 56 && cyc < 3000) begin
                    @(posedge clk); #1;
                    cons_ready = 1'($urandom_range(0, 1));
                    cyc++;
                end
                cons_ready = 1'b0;
            end
        join
        @(negedge clk);
        wrap_phase = 1'b0;
        check("wrap_received", pop_cnt, 56);
        check("wrap_scoreboard_empty", exp_q.size(), 0);
        check("wrap_overflow", overflow, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
